lut_layer_loader: RTL
=====================

# lut_layer_loader

Runtime-programmable LogicNets layer. The block accepts a configuration byte stream that writes the truth tables of N_NEURONS 6-input, 1-output LUT neurons. It then evaluates input vectors against the loaded tables with one registered cycle of latency. It is the writer side of the fixed per-neuron ROM tables: each table is loaded over a handshake instead of being synthesised as constants, so trained layers can be swapped without rebuilding the bitstream.

## Interface
- IN_BITS, 6, fan-in per neuron; table depth is 2^IN_BITS bits; must be >= 3
- N_NEURONS, 8, neurons in the layer
- BEATS_PER_NEURON, 2^IN_BITS/8 (derived, localparam), config bytes per table
- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_valid  input  1  config beat valid
- cfg_ready  output  1  config beat accepted when cfg_valid && cfg_ready
- cfg_data  input  8  eight consecutive truth-table bits
- cfg_sop  input  1  first beat of a frame
- cfg_last  input  1  final beat of a frame
- in_valid  input  1  evaluation vector valid
- in_ready  output  1  evaluation vector accepted when in_valid && in_ready
- in_data  input  N_NEURONS*IN_BITS  neuron n reads in_data[n*IN_BITS +: IN_BITS]
- out_valid  output  1  result valid (single-cycle pulse per accepted vector)
- out_data  output  N_NEURONS  bit n = table_n[in_data slice n]
- table_valid  output  1  a complete, length-checked frame is loaded
- cfg_err  output  1  sticky; set on a framing error, cleared by the next sop

## Operation
- The frame is N_NEURONS*BEATS_PER_NEURON beats. Neuron 0 comes first; within a neuron, beats are ordered from low addresses to high.
- Byte b of neuron n, bit j, is the table entry for input value 8*b+j. The input value is unsigned, with in_data slice bit 0 as the LSB.
- States:
  - IDLE: cfg_ready=1. An accepted beat with cfg_sop goes to LOAD; it is written as beat 0, table_valid->0, cfg_err->0. An accepted beat without sop is dropped and sets cfg_err.
  - LOAD: cfg_ready=1. Each accepted beat is written at beat counter idx, then idx++.
    - cfg_last on beat idx==TOTAL-1: table_valid->1, go to IDLE.
    - cfg_last before that point: cfg_err->1, table_valid stays 0, go to IDLE.
    - Beat TOTAL-1 without cfg_last: cfg_err->1, go to IDLE.
    - cfg_sop in LOAD restarts the frame: the beat is written as beat 0, idx=1, cfg_err is unchanged.
- Single-beat frame (TOTAL==1 only): sop and last on the same beat loads and completes.
- Evaluation:
  - in_ready = table_valid && state==IDLE (registered state, no combinational path from cfg_*).
  - An accepted vector registers out_data next cycle with out_valid=1.
  - Without backpressure on the output, the sink must accept every pulse.
- Simultaneous events: in IDLE with table_valid=1, an in beat and a cfg sop beat in the same cycle are both accepted. The vector is evaluated with the old tables, and the next cycle table_valid=0.
- A partially loaded frame never drives out_data, because in_ready stays 0 until the length check passes.

## Timing
- Reset values: cfg_ready=0 while rst_n low and 1 from the first clock after release; in_ready=0, out_valid=0, out_data=0, table_valid=0, cfg_err=0, state=IDLE, idx=0.
- Table registers are not reset; their contents are don't-care until table_valid.
- Evaluation latency is 1 cycle, with throughput of 1 vector per cycle.
- Config throughput is 1 beat per cycle. After the last beat is accepted in cycle t, table_valid and in_ready are 1 in cycle t+1.
- Reset asserted mid-frame clears state and the counter immediately; table_valid=0 until a full new frame loads.

## Structure
- Shared package lut_layer_pkg holds:
  - state enum {IDLE, LOAD}
  - beat-count width $clog2(N_NEURONS*BEATS_PER_NEURON)
  - the BEATS_PER_NEURON function
- Sub-module lut_neuron_ram (one instance per neuron) has:
  - a 2^IN_BITS-bit register
  - a byte-write port (we, beat index)
  - a combinational read by IN_BITS address
- The top level holds the FSM, counter, neuron select (idx / BEATS_PER_NEURON) and output register.

## Test plan
- Load all-zero frame (64 beats, defaults), then in_data all 0x3F -> out_data=0x00 one cycle later, table_valid=1.
- Load neuron n with table bit k = k[3] (byte pattern 0x00, 0xFF alternating); drive slice values 8 and 7 -> bits 1 and 0 respectively.
- cfg_last on beat 10 -> cfg_err=1, table_valid=0, in_ready=0; next valid frame -> cfg_err=0, table_valid=1.
- Beat without sop in IDLE -> dropped, cfg_err=1; sop mid-LOAD at beat 20 -> restart; 64 further beats with last -> table_valid=1.
- table_valid=1 and old table all-ones; same-cycle in beat + sop beat -> out_data=0xFF next cycle, then table_valid=0, in_ready=0.
- rst_n pulsed low at beat 30 -> all outputs at reset values asynchronously; table_valid stays 0 until a full reload.

Source files
------------

// File: rtl/lut_layer_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT layer.
// Pure declarations: no latency, no flow control.
package lut_layer_pkg;

  typedef enum logic {IDLE, LOAD} state_t;

  // Config bytes needed to fill one 2^in_bits-entry truth table.
  function automatic int beats_per_neuron(input int in_bits);
    return (1 << in_bits) / 8;
  endfunction

  // Counter width for 'total' beats; never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron's truth table: byte-wide write port, combinational bit read.
// Write takes effect next edge; read is same-cycle; no flow control.
module lut_neuron_ram
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS = 6
) (
  input  logic                                      clk,
  input  logic                                      we,
  input  logic [cnt_width(beats_per_neuron(IN_BITS))-1:0] beat,
  input  logic [7:0]                                wdata,
  input  logic [IN_BITS-1:0]                        addr,
  output logic                                      rdata
);

  localparam int BPN = beats_per_neuron(IN_BITS);
  localparam int BW  = cnt_width(BPN);

  logic [(1 << IN_BITS)-1:0] mem;

  // Table contents are deliberately unreset; table_valid gates their use.
  for (genvar b = 0; b < BPN; b++) begin : g_beat
    always_ff @(posedge clk) begin
      if (we && (beat == BW'(b)))
        mem[b*8 +: 8] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lut_layer_loader.sv
// LUT layer whose tables are loaded over a framed byte stream, then evaluated.
// Evaluation: 1 cycle, 1 vector/cycle; in_ready only when a checked frame is loaded and idle.
module lut_layer_loader
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS   = 6,
  parameter int N_NEURONS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [7:0]                     cfg_data,
  input  logic                           cfg_sop,
  input  logic                           cfg_last,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]   in_data,
  output logic                           out_valid,
  output logic [N_NEURONS-1:0]           out_data,
  output logic                           table_valid,
  output logic                           cfg_err
);

  localparam int BPN   = beats_per_neuron(IN_BITS);
  localparam int TOTAL = N_NEURONS * BPN;
  localparam int CW    = cnt_width(TOTAL);
  localparam int BW    = cnt_width(BPN);

  state_t               state, state_nx;
  logic [CW-1:0]        idx, idx_nx, pos;
  logic                 tv_nx, err_nx, rdy_q;
  logic                 cfg_fire, in_fire, we_any;
  logic [N_NEURONS-1:0] nrn_we, rd_bit;
  logic [BW-1:0]        wr_beat;

  assign cfg_ready = rdy_q;
  assign in_ready  = table_valid && (state == IDLE);
  assign cfg_fire  = cfg_valid && rdy_q;
  assign in_fire   = in_valid && in_ready;

  // A sop beat always lands at position 0, even mid-frame.
  assign pos     = cfg_sop ? '0 : idx;
  assign we_any  = cfg_fire && (cfg_sop || (state == LOAD));
  assign wr_beat = BW'(int'(pos) % BPN);

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_nrn
    assign nrn_we[n] = we_any && ((int'(pos) / BPN) == n);

    lut_neuron_ram #(.IN_BITS(IN_BITS)) u_ram (
      .clk   (clk),
      .we    (nrn_we[n]),
      .beat  (wr_beat),
      .wdata (cfg_data),
      .addr  (in_data[n*IN_BITS +: IN_BITS]),
      .rdata (rd_bit[n])
    );
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tv_nx    = table_valid;
    err_nx   = cfg_err;
    if (cfg_fire) begin
      if ((state == IDLE) && !cfg_sop) begin
        err_nx = 1'b1;
      end else begin
        if (cfg_sop) begin
          tv_nx = 1'b0;
          if (state == IDLE)
            err_nx = 1'b0;
        end
        if (pos == CW'(TOTAL - 1)) begin
          if (cfg_last) tv_nx  = 1'b1;
          else          err_nx = 1'b1;
          state_nx = IDLE;
          idx_nx   = '0;
        end else if (cfg_last) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          state_nx = LOAD;
          idx_nx   = pos + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      table_valid <= 1'b0;
      cfg_err     <= 1'b0;
      rdy_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      table_valid <= tv_nx;
      cfg_err     <= err_nx;
      rdy_q       <= 1'b1;
      out_valid   <= in_fire;
      if (in_fire)
        out_data <= rd_bit;
    end
  end

endmodule
